// File: rtl/cp0_except_ctrl.sv
// CP0 exception controller: prioritises MEM-stage exceptions and interrupts, then sequences COMMIT and FLUSH.
// Optional macro TIMER_INT_EN ORs timer_int_i into interrupt line ip[7].
module cp0_except_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        mem_valid_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_addr_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic        stall_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic [31:0] bad_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic [31:0] new_pc_o
);

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

    state_t      state, state_next;
    logic [5:0]  int_meta, sync_int;
    logic [1:0]  flush_cnt;
    logic [31:0] code_q, target_q;
    logic [31:0] code_d, bad_d, target_d;
    logic [7:0]  ip;
    logic        int_req, any_exc, accept;

`ifdef TIMER_INT_EN
    assign ip = {sync_int[5] | timer_int_i, sync_int[4:0], cause_i[9:8]};
    logic unused_bits;
    assign unused_bits = &{1'b0, status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};
`else
    assign ip = {sync_int, cause_i[9:8]};
    logic unused_bits;
    assign unused_bits = &{1'b0, status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0], timer_int_i};
`endif

    assign int_req = (|(ip & status_i[15:8])) && status_i[0] && !status_i[1];
    assign any_exc = adel_if_i | ri_i | ov_i | trap_i | syscall_i | break_i | adel_i | ades_i | eret_i;
    assign accept  = (state == IDLE) && mem_valid_i && !stall_i && (int_req || any_exc);

    // Interrupt outranks every synchronous exception.
    always_comb begin
        code_d   = '0;
        bad_d    = '0;
        target_d = 32'hBFC0_0380;
        if (int_req)        code_d = 32'h1;
        else if (adel_if_i) begin
            code_d = 32'h4;
            bad_d  = mem_pc_i;
        end
        else if (ri_i)      code_d = 32'ha;
        else if (ov_i)      code_d = 32'hc;
        else if (trap_i)    code_d = 32'hd;
        else if (syscall_i) code_d = 32'h8;
        else if (break_i)   code_d = 32'h9;
        else if (adel_i) begin
            code_d = 32'h4;
            bad_d  = mem_addr_i;
        end
        else if (ades_i) begin
            code_d = 32'h5;
            bad_d  = mem_addr_i;
        end
        else if (eret_i) begin
            code_d   = 32'he;
            target_d = epc_i;
        end
    end

    always_comb begin
        state_next   = state;
        excepttype_o = '0;
        flush_o      = 1'b0;
        busy_o       = 1'b0;
        new_pc_o     = '0;
        case (state)
            IDLE: begin
                if (accept) state_next = COMMIT;
            end
            COMMIT: begin
                state_next   = FLUSH;
                excepttype_o = code_q;
                flush_o      = 1'b1;
                busy_o       = 1'b1;
                new_pc_o     = target_q;
            end
            FLUSH: begin
                flush_o  = 1'b1;
                busy_o   = 1'b1;
                new_pc_o = target_q;
                if (flush_cnt == 2'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            int_meta          <= '0;
            sync_int          <= '0;
            flush_cnt         <= '0;
            code_q            <= '0;
            target_q          <= '0;
            exc_pc_o          <= '0;
            bad_addr_o        <= '0;
            is_in_delayslot_o <= 1'b0;
        end else begin
            state    <= state_next;
            int_meta <= int_i;
            sync_int <= int_meta;
            if (state == COMMIT)     flush_cnt <= 2'd2;
            else if (state == FLUSH) flush_cnt <= flush_cnt - 2'd1;
            if (accept) begin
                code_q            <= code_d;
                target_q          <= target_d;
                exc_pc_o          <= mem_pc_i;
                bad_addr_o        <= bad_d;
                is_in_delayslot_o <= mem_in_delayslot_i;
            end
        end
    end

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Self-checking bench for cp0_except_ctrl: directed vector table, corner sequences, random stimulus vs reference model.
module tb_cp0_except_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  int_i = '0;
    logic        timer_int_i = 1'b0;
    logic [31:0] status_i = '0, cause_i = '0, epc_i = '0;
    logic        mem_valid_i = 1'b0, mem_in_delayslot_i = 1'b0;
    logic [31:0] mem_pc_i = '0, mem_addr_i = '0;
    logic [8:0]  flags = '0;
    logic        adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_i, ades_i, eret_i;
    logic        stall_i = 1'b0;
    logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, busy_o;

    assign {adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_i, ades_i, eret_i} = flags;

    cp0_except_ctrl dut (
        .clk(clk), .rst(rst), .int_i(int_i), .timer_int_i(timer_int_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .mem_valid_i(mem_valid_i), .mem_in_delayslot_i(mem_in_delayslot_i),
        .mem_pc_i(mem_pc_i), .mem_addr_i(mem_addr_i),
        .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i), .trap_i(trap_i),
        .syscall_i(syscall_i), .break_i(break_i), .adel_i(adel_i), .ades_i(ades_i),
        .eret_i(eret_i), .stall_i(stall_i),
        .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o), .bad_addr_o(bad_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .busy_o(busy_o),
        .new_pc_o(new_pc_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a countdown of remaining busy cycles plus the last latched record.
    int          remain;
    logic [31:0] m_code, m_tgt, m_pc, m_bad;
    logic        m_ds;
    logic [5:0]  hist[$];

    function automatic logic [31:0] code_of(int unsigned k);
        case (k)
            0: return 32'h4;  1: return 32'ha;  2: return 32'hc;
            3: return 32'hd;  4: return 32'h8;  5: return 32'h9;
            6: return 32'h4;  7: return 32'h5;  default: return 32'he;
        endcase
    endfunction

    function automatic void model_reset();
        remain = 0;
        m_code = '0; m_tgt = '0; m_pc = '0; m_bad = '0; m_ds = 1'b0;
        hist.delete();
    endfunction

    task automatic model_edge();
        logic [5:0] s;
        logic [7:0] ipv;
        logic       ireq;
        int unsigned k;
        if (!rst) begin
            model_reset();
            return;
        end
        s   = (hist.size() >= 2) ? hist[hist.size() - 2] : 6'd0;
        ipv = {s, cause_i[9:8]};
`ifdef TIMER_INT_EN
        ipv[7] = ipv[7] | timer_int_i;
`endif
        ireq = ((ipv & status_i[15:8]) != 8'd0) && status_i[0] && !status_i[1];
        hist.push_back(int_i);
        if (hist.size() > 2) void'(hist.pop_front());
        if (remain > 0) remain--;
        else if (mem_valid_i && !stall_i && (ireq || flags != 9'd0)) begin
            remain = 3;
            m_pc   = mem_pc_i;
            m_ds   = mem_in_delayslot_i;
            m_bad  = '0;
            m_tgt  = 32'hBFC0_0380;
            if (ireq) m_code = 32'h1;
            else begin
                k = 0;
                while (!flags[8 - k]) k++;
                m_code = code_of(k);
                if (k == 0) m_bad = mem_pc_i;
                else if (k == 6 || k == 7) m_bad = mem_addr_i;
                if (k == 8) m_tgt = epc_i;
            end
        end
    endtask

    task automatic expect32(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(string tag);
        logic [31:0] e_type, e_npc;
        logic        act;
        e_type = (remain == 3) ? m_code : 32'h0;
        e_npc  = (remain > 0) ? m_tgt : 32'h0;
        act    = remain > 0;
        vectors++;
        if (excepttype_o !== e_type || new_pc_o !== e_npc || flush_o !== act || busy_o !== act ||
            exc_pc_o !== m_pc || bad_addr_o !== m_bad || is_in_delayslot_o !== m_ds) begin
            miscompares++;
            $display("FAIL %s model: type %h/%h npc %h/%h flush %b/%b busy %b/%b pc %h/%h bad %h/%h ds %b/%b (got/expected) at %0t",
                     tag, excepttype_o, e_type, new_pc_o, e_npc, flush_o, act, busy_o, act,
                     exc_pc_o, m_pc, bad_addr_o, m_bad, is_in_delayslot_o, m_ds, $time);
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag);
    endtask

    typedef struct {
        logic [8:0]  flg;
        logic        ds;
        logic [31:0] pc, addr, epc, code, bad, tgt;
    } vec_t;

    vec_t tbl[11];
    int   seen, flushes;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        // flags: {adel_if, ri, ov, trap, syscall, break, adel, ades, eret}
        tbl[0]  = '{9'h010, 1'b0, 32'hBFC00100, 32'h0,       32'h0,       32'h8, 32'h0,       32'hBFC00380};
        tbl[1]  = '{9'h042, 1'b0, 32'hBFC00104, 32'h80000003, 32'h0,      32'hc, 32'h0,       32'hBFC00380};
        tbl[2]  = '{9'h002, 1'b0, 32'hBFC00108, 32'h80000003, 32'h0,      32'h5, 32'h80000003, 32'hBFC00380};
        tbl[3]  = '{9'h001, 1'b0, 32'hBFC0010C, 32'h0,       32'hBFC00444, 32'he, 32'h0,       32'hBFC00444};
        tbl[4]  = '{9'h180, 1'b0, 32'h80001000, 32'h55555555, 32'h0,      32'h4, 32'h80001000, 32'hBFC00380};
        tbl[5]  = '{9'h0C0, 1'b1, 32'h80001004, 32'h0,       32'h0,       32'ha, 32'h0,       32'hBFC00380};
        tbl[6]  = '{9'h030, 1'b0, 32'h80001008, 32'h0,       32'h0,       32'hd, 32'h0,       32'hBFC00380};
        tbl[7]  = '{9'h00C, 1'b0, 32'h8000100C, 32'hA0000001, 32'h0,      32'h9, 32'h0,       32'hBFC00380};
        tbl[8]  = '{9'h004, 1'b1, 32'h80001010, 32'h12345671, 32'h0,      32'h4, 32'h12345671, 32'hBFC00380};
        tbl[9]  = '{9'h011, 1'b0, 32'h80001014, 32'h0,       32'h11111111, 32'h8, 32'h0,      32'hBFC00380};
        tbl[10] = '{9'h020, 1'b1, 32'h80001018, 32'h0,       32'h0,       32'hd, 32'h0,       32'hBFC00380};

        model_reset();
        repeat (2) @(negedge clk);
        check("reset");
        expect32("reset_flush", {31'b0, flush_o}, 32'h0);
        rst = 1'b1;
        tick("release");

        // Directed vector table: accept, then COMMIT / FLUSH / FLUSH / IDLE.
        mem_valid_i = 1'b1;
        for (int unsigned i = 0; i < 11; i++) begin
            flags = tbl[i].flg; mem_in_delayslot_i = tbl[i].ds;
            mem_pc_i = tbl[i].pc; mem_addr_i = tbl[i].addr; epc_i = tbl[i].epc;
            tick("vec_accept");
            expect32("vec_code", excepttype_o, tbl[i].code);
            expect32("vec_bad", bad_addr_o, tbl[i].bad);
            expect32("vec_pc", exc_pc_o, tbl[i].pc);
            expect32("vec_ds", {31'b0, is_in_delayslot_o}, {31'b0, tbl[i].ds});
            expect32("vec_newpc", new_pc_o, tbl[i].tgt);
            flags = '0;
            flushes = int'(flush_o);
            for (int unsigned j = 0; j < 3; j++) begin
                tick("vec_flush");
                flushes += int'(flush_o);
            end
            expect32("vec_flush_cycles", flushes, 32'd3);
            expect32("vec_idle", {31'b0, busy_o}, 32'h0);
        end

        // Interrupt through synchroniser.
        status_i = 32'h0000FF01;
        int_i = 6'b000100;
        seen = 0;
        for (int unsigned j = 1; j <= 8 && seen == 0; j++) begin
            tick("int_wait");
            if (excepttype_o != 32'h0) seen = j;
        end
        expect32("int_latency", seen, 32'd3);
        expect32("int_code", excepttype_o, 32'h1);
        int_i = '0;
        repeat (3) tick("int_flush");

        status_i = 32'h0000FF03;
        int_i = 6'b000100;
        seen = 0;
        repeat (6) begin
            tick("int_masked");
            if (excepttype_o != 32'h0) seen++;
        end
        expect32("int_exl_blocked", seen, 32'd0);
        int_i = '0; status_i = '0;
        repeat (3) tick("int_clear");

        // ERET with a syscall pulse landing in FLUSH.
        flags = 9'h001; epc_i = 32'hBFC00444;
        tick("eret_accept");
        expect32("eret_code", excepttype_o, 32'he);
        flags = '0;
        tick("eret_flush1");
        expect32("eret_newpc", new_pc_o, 32'hBFC00444);
        flags = 9'h010;
        tick("eret_flush2");
        flags = '0;
        seen = 0;
        repeat (4) begin
            tick("eret_after");
            if (excepttype_o != 32'h0) seen++;
        end
        expect32("eret_pulse_ignored", seen, 32'd0);

        // Asynchronous reset in the first FLUSH cycle.
        flags = 9'h010; mem_pc_i = 32'hBFC00200;
        tick("rst_accept");
        flags = '0;
        tick("rst_flush1");
        expect32("rst_flush_before", {31'b0, flush_o}, 32'h1);
        rst = 1'b0;
        model_reset();
        #1;
        expect32("rst_flush_async", {31'b0, flush_o}, 32'h0);
        expect32("rst_pc_async", exc_pc_o, 32'h0);
        check("rst_async");
        repeat (2) tick("rst_hold");
        rst = 1'b1;
        tick("rst_release");
        expect32("rst_idle", {31'b0, busy_o}, 32'h0);

        // Stall holds off a break.
        stall_i = 1'b1; flags = 9'h008;
        seen = 0;
        repeat (3) begin
            tick("stall_hold");
            if (busy_o) seen++;
        end
        expect32("stall_blocks", seen, 32'd0);
        stall_i = 1'b0;
        tick("stall_release");
        expect32("stall_code", excepttype_o, 32'h9);
        flags = '0;
        repeat (3) tick("stall_flush");

        // Timer interrupt line.
        status_i = 32'h00008001; timer_int_i = 1'b1;
        tick("timer");
`ifdef TIMER_INT_EN
        expect32("timer_code", excepttype_o, 32'h1);
`else
        expect32("timer_code", excepttype_o, 32'h0);
`endif
        timer_int_i = 1'b0; status_i = '0;
        repeat (4) tick("timer_after");

        // Randomised stimulus against the model.
        for (int unsigned n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) != 0);
            if (!rst) model_reset();
            flags = 9'($urandom & $urandom & $urandom);
            int_i = 6'($urandom & $urandom & $urandom);
            timer_int_i = ($urandom_range(0, 7) == 0);
            status_i = {16'h0, 8'($urandom_range(0, 255)), 6'b0,
                        1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
            cause_i = $urandom;
            epc_i = $urandom; mem_pc_i = $urandom; mem_addr_i = $urandom;
            mem_valid_i = ($urandom_range(0, 3) != 0);
            mem_in_delayslot_i = 1'($urandom);
            stall_i = ($urandom_range(0, 3) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
